// File: rtl/mm_slave_checker.sv
// ---------------------------------------------------------------------------
// mm_slave_checker
//
// Memory-mapped slave with a never-stalling single-word write/read port and
// a write-sequence checker. Reads return data with a fixed two-cycle latency.
// The checker expects each write to land on the address after the previous
// one and to carry its own address as data. It counts writes and sequence
// errors.
//
// Handshake: there is no waitrequest. A request is accepted in any cycle
// where write or read is high at a rising edge of CLK. Each accepted read
// produces exactly one readdatavalid pulse. The pulse is observed high at
// the second rising edge after the read is sampled. Responses come back in
// request order. readdata is 0 whenever readdatavalid is low.
//
// Ports
//   CLK           : clock, all state changes on the rising edge
//   reset         : synchronous active-high reset (clears memory too)
//   address       : word address shared by the write and read of this cycle
//   write         : write request, writedata stored at address
//   writedata     : write data
//   read          : read request
//   readdata      : read result, 0 while readdatavalid is low
//   readdatavalid : one-cycle pulse per accepted read
//   wr_count      : accepted writes since reset (wraps)
//   err_count     : sequence errors since reset (saturates at 255)
//   seq_err       : sticky error flag, cleared only by reset
//   chk_state     : checker FSM state (IDLE=0, TRACK=1, ERR=2)
// ---------------------------------------------------------------------------
module mm_slave_checker #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic              read,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic [15:0]       wr_count,
    output logic [7:0]        err_count,
    output logic              seq_err,
    output logic [1:0]        chk_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERR   = 2'd2
    } chk_state_e;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write) begin
            mem_q[address] <= writedata;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 1 captures the word at the sampling edge, the
    // output stage presents it one edge later.
    // ------------------------------------------------------------------
    logic              rd_vld1_q, rd_vld1_d;
    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic              rdv_q, rdv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rd_vld1_d  = read;
        rd_data1_d = '0;
        if (read) begin
            // Read and write share the address, so a simultaneous write is
            // always a same-address collision: forward the new data.
            rd_data1_d = write ? writedata : mem_q[address];
        end
        rdv_d   = rd_vld1_q;
        rdata_d = rd_vld1_q ? rd_data1_q : '0;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rd_vld1_q  <= 1'b0;
            rd_data1_q <= '0;
            rdv_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rd_vld1_q  <= rd_vld1_d;
            rd_data1_q <= rd_data1_d;
            rdv_q      <= rdv_d;
            rdata_q    <= rdata_d;
        end
    end

    assign readdatavalid = rdv_q;
    assign readdata      = rdata_q;

    // ------------------------------------------------------------------
    // Sequence checker
    // ------------------------------------------------------------------
    chk_state_e        state_q, state_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              seq_err_q, seq_err_d;
    logic              log_err;
    logic              data_match;
    logic [MAX_W-1:0]  addr_wide;
    logic [DATA_W-1:0] addr_as_data;

    // Address zero-extended or truncated to the data width.
    always_comb begin
        addr_wide    = MAX_W'(address);
        addr_as_data = addr_wide[DATA_W-1:0];
        data_match   = (writedata == addr_as_data);
    end

    always_comb begin
        state_d    = state_q;
        exp_addr_d = exp_addr_q;
        log_err    = 1'b0;

        if (write) begin
            // Every write resyncs the expected address; wrap at the top of
            // the address space is natural modulo arithmetic.
            exp_addr_d = address + ADDR_W'(1);
            case (state_q)
                ST_IDLE: begin
                    state_d = data_match ? ST_TRACK : ST_ERR;
                    log_err = !data_match;
                end
                ST_TRACK: begin
                    if (data_match && (address == exp_addr_q)) begin
                        state_d = ST_TRACK;
                    end else begin
                        state_d = ST_ERR;
                        log_err = 1'b1;
                    end
                end
                ST_ERR: begin
                    state_d = data_match ? ST_TRACK : ST_ERR;
                    log_err = !data_match;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        wr_count_d  = write ? (wr_count_q + 16'd1) : wr_count_q;
        err_count_d = (log_err && (err_count_q != 8'hFF)) ? (err_count_q + 8'd1)
                                                         : err_count_q;
        seq_err_d   = seq_err_q | log_err;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            exp_addr_q  <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_addr_q  <= exp_addr_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign wr_count  = wr_count_q;
    assign err_count = err_count_q;
    assign seq_err   = seq_err_q;
    assign chk_state = state_q;

endmodule
